main_fsm: RTL and testbench

//  Multicycle ARM control FSM; drives the datapath and the condition unit.
//  - Produces the raw enables the condition unit gates with CondEx:

---
 rtl/main_fsm.sv | 179 +++++++++++++++++
 tb/tb_main_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// main_fsm -- multicycle ARM control FSM.
//
// Sequences each instruction through FETCH/DECODE and a class-specific tail
// (memory, data-processing, branch). It drives the datapath mux selects and
// ALUControl, plus the raw write enables (PCS, RegW, MemW, FlagW, LinkW).
// The condition unit gates these enables with CondEx. Outputs decode from the
// state register and the Op/Funct/Rd fields of the held instruction.
//
// Optional feature macro: MAIN_FSM_BL_EN
//   defined   : a BRANCH with Funct[4]=1 also asserts LinkW and RegW (R14 <- PC+4)
//   undefined : LinkW is tied 0 and BL behaves as B
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   Op[1:0]    in   instr[27:26]
//   Funct[5:0] in   instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (L for memory ops)
//   Rd[3:0]    in   instr[15:12]; 15 marks a PC-destination write
//   IRWrite    out  load instruction register
//   NextPC     out  write PC with PC+4
//   PCS        out  PC write request (branch, or RegW with Rd==15)
//   RegW       out  register-file write request
//   MemW       out  data-memory write request
//   FlagW[1:0] out  [1]=N,Z write, [0]=C,V write
//   AdrSrc     out  memory address: 0=PC, 1=ALUOut
//   ALUSrcA    out  0=RD1, 1=PC
//   ALUSrcB    out  00=RD2, 01=ExtImm, 10=const 4
//   ResultSrc  out  00=ALUOut, 01=ReadData, 10=ALUResult
//   ALUControl out  00=ADD 01=SUB 10=AND 11=ORR
//   LinkW      out  write R14 <- PC+4 this cycle
//   Illegal    out  sticky: unsupported Op decoded
module main_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       LinkW,
  output logic       Illegal
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_UNKNOWN
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q;

  logic [1:0] cmd_alu;
  logic [1:0] cmd_flagw;
  logic       pc_dest;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && Op == 2'b11) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:  state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_UNKNOWN: state_d = S_UNKNOWN;
      default:   state_d = S_FETCH;
    endcase
  end

  // Unrecognised cmd falls back to ADD and never writes flags.
  always_comb begin
    cmd_alu   = 2'b00;
    cmd_flagw = 2'b00;
    unique case (Funct[4:1])
      4'b0100: begin cmd_alu = 2'b00; cmd_flagw = 2'b11; end
      4'b0010: begin cmd_alu = 2'b01; cmd_flagw = 2'b11; end
      4'b0000: begin cmd_alu = 2'b10; cmd_flagw = 2'b10; end
      4'b1100: begin cmd_alu = 2'b11; cmd_flagw = 2'b10; end
      default: begin cmd_alu = 2'b00; cmd_flagw = 2'b00; end
    endcase
    if (!Funct[0]) cmd_flagw = 2'b00;
  end

  assign pc_dest = (Rd == 4'd15);

  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    FlagW      = '0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = '0;
    ResultSrc  = '0;
    ALUControl = '0;
    LinkW      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1; NextPC = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01; RegW = 1'b1; PCS = pc_dest;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; MemW = 1'b1;
      end
      S_EXECR: begin
        ALUSrcB = 2'b00; ALUControl = cmd_alu; FlagW = cmd_flagw;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01; ALUControl = cmd_alu; FlagW = cmd_flagw;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00; RegW = 1'b1; PCS = pc_dest;
      end
      S_BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; PCS = 1'b1;
`ifdef MAIN_FSM_BL_EN
        LinkW = Funct[4];
        RegW  = Funct[4];
`endif
      end
      default: ;
    endcase
    // Reset drops any pending write in the cycle it is held, whatever the state.
    if (reset) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      PCS     = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      FlagW   = '0;
      LinkW   = 1'b0;
    end
  end

  assign Illegal = illegal_q;

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, NextPC, PCS, RegW, MemW, AdrSrc, ALUSrcA, LinkW, Illegal;
  logic [1:0] FlagW, ALUSrcB, ResultSrc, ALUControl;

  main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .FlagW(FlagW), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .LinkW(LinkW),
    .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: irw16 npc15 pcs14 regw13 memw12 flagw11:10 adr9 srca8
  // srcb7:6 res5:4 aluc3:2 link1 ill0
  localparam logic [16:0] KEEP_IN_RESET = 17'b00000001111111101;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = -100;
  bit          chk_en = 1'b0;
  logic [16:0] exp_vec;
  logic [16:0] dlog [0:63];
  int          kph = 0;   // cycle index within the current instruction

`ifdef MAIN_FSM_BL_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  // Expected outputs for cycle k of an instruction, from the instruction's class.
  function automatic logic [16:0] expv(input logic [1:0] op, input logic [5:0] f,
                                       input logic [3:0] rd, input int k);
    logic irw, npc, pcs, regw, memw, adr, srca, link, ill;
    logic [1:0] flagw, srcb, res, aluc;
    {irw, npc, pcs, regw, memw, adr, srca, link, ill} = '0;
    {flagw, srcb, res, aluc} = '0;
    if (k == 0) begin
      irw = 1; npc = 1; srca = 1; srcb = 2'b10; res = 2'b10;
    end else if (k == 1) begin
      srca = 1; srcb = 2'b10; res = 2'b10;
    end else begin
      case (op)
        2'b01: begin
          if (k == 2) srcb = 2'b01;
          else if (k == 3) begin adr = 1; memw = !f[0]; end
          else begin res = 2'b01; regw = 1; pcs = (rd == 4'd15); end
        end
        2'b00: begin
          if (k == 2) begin
            srcb = f[5] ? 2'b01 : 2'b00;
            case (f[4:1])
              4'b0100: begin aluc = 2'd0; flagw = f[0] ? 2'b11 : 2'b00; end
              4'b0010: begin aluc = 2'd1; flagw = f[0] ? 2'b11 : 2'b00; end
              4'b0000: begin aluc = 2'd2; flagw = f[0] ? 2'b10 : 2'b00; end
              4'b1100: begin aluc = 2'd3; flagw = f[0] ? 2'b10 : 2'b00; end
              default: begin aluc = 2'd0; flagw = 2'b00; end
            endcase
          end else begin
            regw = 1; pcs = (rd == 4'd15);
          end
        end
        2'b10: begin
          pcs = 1; srcb = 2'b01; res = 2'b10;
          regw = BL && f[4]; link = BL && f[4];
        end
        default: ill = 1;
      endcase
    end
    return {irw, npc, pcs, regw, memw, flagw, adr, srca, srcb, res, aluc, link, ill};
  endfunction

  function automatic int seqlen(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00:   return 4;
      2'b01:   return f[0] ? 5 : 4;
      2'b10:   return 3;
      default: return 1000000;
    endcase
  endfunction

  // Single compare process: DUT vs model on every falling edge.
  always @(negedge clk) begin
    logic [16:0] got;
    got = {IRWrite, NextPC, PCS, RegW, MemW, FlagW, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ALUControl, LinkW, Illegal};
    if (cyc >= 0 && cyc < 64) dlog[cyc] = got;
    if (chk_en) begin
      n_cmp++;
      if (got !== exp_vec) begin
        n_bad++;
        $display("FAIL model cyc=%0d op=%b funct=%b rd=%0d rst=%b: got %b want %b",
                 cyc, Op, Funct, Rd, reset, got, exp_vec);
      end
    end
  end

  task automatic lit(input string name, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // One clock cycle: drive reset, set expectation, advance model at the edge.
  task automatic tick(input logic rst);
    reset   = rst;
    exp_vec = expv(Op, Funct, Rd, kph) & (rst ? KEEP_IN_RESET : '1);
    chk_en  = 1'b1;
    @(posedge clk);
    if (rst) kph = 0;
    else if (kph + 1 >= seqlen(Op, Funct)) kph = 0;
    else if (!(Op == 2'b11 && kph >= 2)) kph++;
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input int n);
    Op = op; Funct = f; Rd = rd;
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  initial begin
    int stuck;
    logic [3:0] cmd;
    int r;
    reset = 1'b1; Op = '0; Funct = '0; Rd = '0;
    @(posedge clk); #1;
    cyc = -2;
    tick(1'b1);
    tick(1'b1);

    // Directed instruction stream starting at cyc 0.
    issue(2'b00, 6'b001001, 4'd1, 4);   // ADDS reg   c0..c3
    issue(2'b00, 6'b100001, 4'd2, 4);   // ANDS imm   c4..c7
    issue(2'b01, 6'b011001, 4'd3, 5);   // LDR        c8..c12
    issue(2'b01, 6'b011000, 4'd4, 4);   // STR        c13..c16
    issue(2'b10, 6'b010000, 4'd0, 3);   // B / BL     c17..c19
    issue(2'b11, 6'b000000, 4'd0, 6);   // Op=11      c20..c25
    tick(1'b1); tick(1'b1);             // c26, c27
    issue(2'b00, 6'b001000, 4'd15, 3);  // ADD pc     c28..c30
    tick(1'b1);                         // reset in ALUWB, c31
    tick(1'b0);                         // c32

    lit("rel_irwrite", {3'b0, dlog[0][16]}, 4'd1);
    lit("rel_nextpc",  {3'b0, dlog[0][15]}, 4'd1);
    lit("decode_en",   {1'b0, dlog[1][16:14]} | {1'b0, dlog[1][13:12], dlog[1][1]}
                       | {2'b0, dlog[1][11:10]}, 4'd0);
    lit("adds_flagw",  {2'b0, dlog[2][11:10]}, 4'd3);
    lit("adds_aluc",   {2'b0, dlog[2][3:2]}, 4'd0);
    lit("adds_regw",   {3'b0, dlog[3][13]}, 4'd1);
    lit("ands_flagw",  {2'b0, dlog[6][11:10]}, 4'd2);
    lit("ands_srcb",   {2'b0, dlog[6][7:6]}, 4'd1);
    lit("ands_aluc",   {2'b0, dlog[6][3:2]}, 4'd2);
    lit("ldr_adrsrc",  {3'b0, dlog[11][9]}, 4'd1);
    lit("ldr_res",     {2'b0, dlog[12][5:4]}, 4'd1);
    lit("ldr_regw",    {3'b0, dlog[12][13]}, 4'd1);
    lit("str_memw",    {3'b0, dlog[16][12]}, 4'd1);
    lit("b_pcs",       {3'b0, dlog[19][14]}, 4'd1);
    lit("bl_linkw",    {3'b0, dlog[19][1]}, {3'b0, BL});
    lit("bl_regw",     {3'b0, dlog[19][13]}, {3'b0, BL});
    lit("illegal",     {3'b0, dlog[25][0]}, 4'd1);
    lit("illegal_rst", {3'b0, dlog[27][0]}, 4'd0);
    lit("add_nos_fw",  {2'b0, dlog[30][11:10]}, 4'd0);
    lit("rst_wb_regw", {3'b0, dlog[31][13]}, 4'd0);
    lit("rst_wb_pcs",  {3'b0, dlog[31][14]}, 4'd0);
    lit("post_rst_ir", {3'b0, dlog[32][16]}, 4'd1);
    for (int c = 0; c <= 20; c++) begin
      lit("fetch_spacing", {3'b0, dlog[c][16]},
          {3'b0, (c == 0 || c == 4 || c == 8 || c == 13 || c == 17 || c == 20)});
    end

    // Randomized stream with occasional mid-instruction resets.
    stuck = 0;
    for (int n = 0; n < 3000; n++) begin
      if (kph == 0) begin
        r = $urandom_range(0, 9);
        Op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        case ($urandom_range(0, 4))
          0: cmd = 4'b0100;
          1: cmd = 4'b0010;
          2: cmd = 4'b0000;
          3: cmd = 4'b1100;
          default: cmd = 4'($urandom);
        endcase
        Funct = {1'($urandom), cmd, 1'($urandom)};
        Rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      end
      if (Op == 2'b11 && kph == 2) stuck++;
      else stuck = 0;
      tick(($urandom_range(0, 99) < 3) || stuck >= 4);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
